// File: rtl/banked_main_mem.sv
// Four-bank interleaved 64 KB word memory (bank = addr[2:1], row = addr[15:3]).
// Latency: write lands on the accept edge; read data on data_out two cycles after accept.
// Backpressure: a legal request to a busy bank raises stall and is dropped; requester retries.
module banked_main_mem #(
  parameter int BUSY_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] addr,
  input  logic [15:0] data_in,
  input  logic        wr,
  input  logic        rd,
  output logic [15:0] data_out,
  output logic        stall,
  output logic [3:0]  busy,
  output logic        err
);

  localparam logic [3:0] BUSY_LOAD = 4'(BUSY_CYCLES);

  logic [1:0]  bank;
  logic [12:0] row;
  logic        req;
  logic        illegal;
  logic        legal;
  logic        accept;

  // Bank arrays start zeroed at time 0 and are never cleared by reset.
  logic [15:0] mem [4][8192] = '{default: '0};

  logic [3:0]  cnt [4];
  logic        rd_vld1;
  logic [15:0] rd_dat1;

  assign bank    = addr[2:1];
  assign row     = addr[15:3];
  assign req     = rd | wr;
  assign illegal = (rd & wr) | (req & addr[0]);

  // Request decode: reset masks every request and every flag.
  always_comb begin
    legal  = req & ~illegal & ~rst;
    err    = illegal & ~rst;
    stall  = legal & busy[bank];
    accept = legal & ~busy[bank];
  end

  // A bank is busy while its down-counter is non-zero; no bypass on the release edge.
  always_comb begin
    busy = '0;
    for (int i = 0; i < 4; i++) begin
      busy[i] = (cnt[i] != 4'd0);
    end
  end

  // Per-bank busy counters: load on accept, count down to zero otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        cnt[i] <= 4'd0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (accept && (bank == 2'(i))) begin
          cnt[i] <= BUSY_LOAD;
        end else if (cnt[i] != 4'd0) begin
          cnt[i] <= cnt[i] - 4'd1;
        end
      end
    end
  end

  // Array write port and synchronous read into the first pipe stage (contents survive reset).
  always_ff @(posedge clk) begin
    if (accept && wr) begin
      mem[bank][row] <= data_in;
    end
    if (accept && rd) begin
      rd_dat1 <= mem[bank][row];
    end
  end

  // Read pipe: stage-1 valid then registered output, zero whenever no read completes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_vld1  <= 1'b0;
      data_out <= 16'h0000;
    end else begin
      rd_vld1  <= accept & rd;
      data_out <= rd_vld1 ? rd_dat1 : 16'h0000;
    end
  end

endmodule

// File: tb/tb_banked_main_mem.sv
// Directed bench for banked_main_mem with a scoreboard queue of expected read data.
// Stimulus drives and checks combinational flags at negedge+1; the monitor checks data_out at negedge.
// Expected read data is hand-computed per vector and pushed with the cycle it is due.
module tb_banked_main_mem;

  localparam int BC = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] addr;
  logic [15:0] data_in;
  logic        wr;
  logic        rd;
  logic [15:0] data_out;
  logic        stall;
  logic [3:0]  busy;
  logic        err;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    int          due;
    logic [15:0] val;
  } exp_t;

  exp_t sb_q[$];

  banked_main_mem #(.BUSY_CYCLES(BC)) dut (
    .clk      (clk),
    .rst      (rst),
    .addr     (addr),
    .data_in  (data_in),
    .wr       (wr),
    .rd       (rd),
    .data_out (data_out),
    .stall    (stall),
    .busy     (busy),
    .err      (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (cycle %0d): got %h, expected %h", nm, cyc, act, exp);
    end
  endtask

  // Monitor: data_out must equal the queued word in its due cycle and be zero otherwise.
  always @(negedge clk) begin
    if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
      check("read_data", int'(data_out), int'(sb_q[0].val));
      void'(sb_q.pop_front());
    end else if (sb_q.size() > 0 && sb_q[0].due < cyc) begin
      check("read_missed", cyc, sb_q[0].due);
      void'(sb_q.pop_front());
    end else begin
      check("data_out_idle_zero", int'(data_out), 0);
    end
  end

  // One request cycle; eb < 0 skips the busy check, push queues expected read data.
  task automatic issue(input logic r, input logic w, input logic [15:0] a, input logic [15:0] d,
                       input logic es, input logic ee, input int eb,
                       input logic [15:0] ed, input bit push);
    @(negedge clk);
    rd = r; wr = w; addr = a; data_in = d;
    #1;
    check("stall", int'(stall), int'(es));
    check("err", int'(err), int'(ee));
    if (eb >= 0) check("busy", int'(busy), eb);
    if (push) sb_q.push_back('{due: cyc + 2, val: ed});
  endtask

  task automatic idle(input int eb);
    @(negedge clk);
    rd = 1'b0; wr = 1'b0;
    #1;
    if (eb >= 0) check("busy_idle", int'(busy), eb);
  endtask

  initial begin
    rst = 1'b1; rd = 1'b0; wr = 1'b0; addr = 16'h0; data_in = 16'h0;

    // Reset holds every output low whatever the inputs do.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      rd = 1'b1; wr = (i == 0); addr = 16'h0010; data_in = 16'h1234;
      #1;
      check("rst_busy", int'(busy), 0);
      check("rst_stall", int'(stall), 0);
      check("rst_err", int'(err), 0);
      check("rst_data_out", int'(data_out), 0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0; rd = 1'b0; wr = 1'b0;

    // Write BEEF @0x0010 on the first edge after reset, read back after bank frees.
    issue(1'b0, 1'b1, 16'h0010, 16'hBEEF, 1'b0, 1'b0, 0, 16'h0, 1'b0);
    for (int i = 0; i < BC; i++) idle(1);
    issue(1'b1, 1'b0, 16'h0010, 16'h0, 1'b0, 1'b0, 0, 16'hBEEF, 1'b1);
    for (int i = 0; i < BC; i++) idle(-1);

    // Preload one word per bank on consecutive cycles, then pipelined reads.
    issue(1'b0, 1'b1, 16'h0000, 16'h0001, 1'b0, 1'b0, 4'b0000, 16'h0, 1'b0);
    issue(1'b0, 1'b1, 16'h0002, 16'h0002, 1'b0, 1'b0, 4'b0001, 16'h0, 1'b0);
    issue(1'b0, 1'b1, 16'h0004, 16'h0003, 1'b0, 1'b0, 4'b0011, 16'h0, 1'b0);
    issue(1'b0, 1'b1, 16'h0006, 16'h0004, 1'b0, 1'b0, 4'b0111, 16'h0, 1'b0);
    idle(4'b1111);
    for (int i = 0; i < BC; i++) idle(-1);
    issue(1'b1, 1'b0, 16'h0000, 16'h0, 1'b0, 1'b0, 4'b0000, 16'h0001, 1'b1);
    issue(1'b1, 1'b0, 16'h0002, 16'h0, 1'b0, 1'b0, 4'b0001, 16'h0002, 1'b1);
    issue(1'b1, 1'b0, 16'h0004, 16'h0, 1'b0, 1'b0, 4'b0011, 16'h0003, 1'b1);
    issue(1'b1, 1'b0, 16'h0006, 16'h0, 1'b0, 1'b0, 4'b0111, 16'h0004, 1'b1);
    for (int i = 0; i < BC + 1; i++) idle(-1);

    // Same-bank conflict: read of never-written 0x0008, then 0x0018 stalls until bank 0 frees.
    issue(1'b0, 1'b1, 16'h0018, 16'h5A5A, 1'b0, 1'b0, 0, 16'h0, 1'b0);
    for (int i = 0; i < BC + 1; i++) idle(-1);
    issue(1'b1, 1'b0, 16'h0008, 16'h0, 1'b0, 1'b0, 0, 16'h0000, 1'b1);
    for (int i = 0; i < BC; i++)
      issue(1'b1, 1'b0, 16'h0018, 16'h0, 1'b1, 1'b0, 4'b0001, 16'h0, 1'b0);
    issue(1'b1, 1'b0, 16'h0018, 16'h0, 1'b0, 1'b0, 0, 16'h5A5A, 1'b1);
    for (int i = 0; i < BC + 1; i++) idle(-1);

    // Illegal requests raise err only, even against a busy bank.
    issue(1'b1, 1'b1, 16'h0020, 16'hFFFF, 1'b0, 1'b1, 0, 16'h0, 1'b0);
    issue(1'b1, 1'b0, 16'h0021, 16'h0, 1'b0, 1'b1, 0, 16'h0, 1'b0);
    idle(0);
    issue(1'b1, 1'b0, 16'h0000, 16'h0, 1'b0, 1'b0, 0, 16'h0001, 1'b1);
    issue(1'b0, 1'b1, 16'h0001, 16'hDEAD, 1'b0, 1'b1, 4'b0001, 16'h0, 1'b0);
    idle(4'b0001);
    for (int i = 0; i < BC + 1; i++) idle(-1);

    // Reset pulse cancels an in-flight read and frees banks; arrays keep their data.
    issue(1'b1, 1'b0, 16'h0010, 16'h0, 1'b0, 1'b0, 0, 16'h0, 1'b0);
    @(negedge clk);
    rst = 1'b1; rd = 1'b0; wr = 1'b0;
    #1;
    check("midrst_busy", int'(busy), 0);
    check("midrst_data_out", int'(data_out), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    issue(1'b1, 1'b0, 16'h0010, 16'h0, 1'b0, 1'b0, 0, 16'hBEEF, 1'b1);
    issue(1'b1, 1'b0, 16'h0002, 16'h0, 1'b0, 1'b0, 4'b0001, 16'h0002, 1'b1);
    issue(1'b1, 1'b0, 16'h0000, 16'h0, 1'b1, 1'b0, 4'b0011, 16'h0, 1'b0);
    for (int i = 0; i < BC + 2; i++) idle(-1);

    check("queue_drained", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
